// File: rtl/times_table_checker.sv
// Self-test sequencer for the times-table memory: sweeps all 64 {a,b}
// addresses, realigns returned products and reports a verdict.
module times_table_checker #(
    parameter int READ_LATENCY = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       rom_en,
    output logic [2:0] rom_a,
    output logic [2:0] rom_b,
    input  logic [5:0] rom_result,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [6:0] err_count,
    output logic       first_err_valid,
    output logic [5:0] first_err_addr
);

    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        DRAIN,
        DONE
    } state_t;

    state_t     state;
    logic [5:0] addr;
    logic       chk_valid;
    logic [5:0] chk_addr;
    logic       pipe_busy;
    logic [5:0] prod;
    logic       mismatch;

    assign rom_a = addr[5:3];
    assign rom_b = addr[2:0];

    // {rom_en,addr} is the first alignment stage; later stages follow it
    generate
        if (READ_LATENCY <= 1) begin : g_direct
            assign chk_valid = rom_en;
            assign chk_addr  = addr;
            assign pipe_busy = 1'b0;
        end else begin : g_pipe
            localparam int D = READ_LATENCY - 1;
            logic [D-1:0] pv;
            logic [5:0]   pa [D];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    pv <= '0;
                    for (int i = 0; i < D; i++) begin
                        pa[i] <= '0;
                    end
                end else begin
                    pv[0] <= rom_en;
                    pa[0] <= addr;
                    for (int i = 1; i < D; i++) begin
                        pv[i] <= pv[i-1];
                        pa[i] <= pa[i-1];
                    end
                end
            end

            assign chk_valid = pv[D-1];
            assign chk_addr  = pa[D-1];
            assign pipe_busy = |pv;
        end
    endgenerate

    assign prod     = {3'b000, chk_addr[5:3]} * {3'b000, chk_addr[2:0]};
    assign mismatch = chk_valid && (rom_result != prod);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            addr            <= '0;
            rom_en          <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_addr  <= '0;
        end else begin
            done <= 1'b0;
            if (mismatch) begin
                err_count <= err_count + 7'd1;
                if (!first_err_valid) begin
                    first_err_valid <= 1'b1;
                    first_err_addr  <= chk_addr;
                end
            end
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state           <= SWEEP;
                        addr            <= '0;
                        rom_en          <= 1'b1;
                        busy            <= 1'b1;
                        pass            <= 1'b0;
                        err_count       <= '0;
                        first_err_valid <= 1'b0;
                        first_err_addr  <= '0;
                    end
                end
                SWEEP: begin
                    addr <= addr + 6'd1;
                    if (addr == 6'd63) begin
                        state  <= DRAIN;
                        rom_en <= 1'b0;
                    end
                end
                DRAIN: begin
                    // last compare has already landed once the pipe is empty
                    if (!pipe_busy) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_count == 7'd0);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_times_table_checker.sv
// Scoreboard bench for times_table_checker: two instances (latency 1 and 2)
// each fed by a behavioural times-table memory with selectable faults.
module tb_times_table_checker;

    typedef struct {
        int cyc;
        int pass;
        int err;
        int fev;
        int fea;
        int busy;
    } verdict_t;

    logic       clk;
    logic       rst;
    logic       start1, start2;
    logic       rom_en1, rom_en2;
    logic [2:0] rom_a1, rom_b1, rom_a2, rom_b2;
    logic [5:0] rom_result1, rom_result2;
    logic       busy1, busy2, done1, done2, pass1, pass2;
    logic [6:0] err1, err2;
    logic       fev1, fev2;
    logic [5:0] fea1, fea2;

    int mode1, mlat1, mode2;
    int cyc;
    int n_checks, n_fail;
    int bc1, ec1, bc2;
    verdict_t vq1[$];
    verdict_t vq2[$];
    int aq1[$];
    logic [5:0] cur1, h1, cur2, h2;

    times_table_checker #(.READ_LATENCY(1)) u1 (
        .clk(clk), .rst(rst), .start(start1),
        .rom_en(rom_en1), .rom_a(rom_a1), .rom_b(rom_b1),
        .rom_result(rom_result1),
        .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .first_err_valid(fev1),
        .first_err_addr(fea1)
    );

    times_table_checker #(.READ_LATENCY(2)) u2 (
        .clk(clk), .rst(rst), .start(start2),
        .rom_en(rom_en2), .rom_a(rom_a2), .rom_b(rom_b2),
        .rom_result(rom_result2),
        .busy(busy2), .done(done2), .pass(pass2),
        .err_count(err2), .first_err_valid(fev2),
        .first_err_addr(fea2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [5:0] tt(input int mode, input int adr);
        int a;
        int b;
        a = adr / 8;
        b = adr % 8;
        case (mode)
            1: return (a == 5 && b == 7) ? 6'd36 : 6'(a * b);
            2: return 6'd0;
            default: return 6'(a * b);
        endcase
    endfunction

    // memory models: latency 1 reads combinationally, latency 2 adds a register
    assign cur1 = tt(mode1, int'({rom_a1, rom_b1}));
    assign cur2 = tt(mode2, int'({rom_a2, rom_b2}));
    always @(posedge clk) begin
        h1 <= cur1;
        h2 <= cur2;
    end
    assign rom_result1 = (mlat1 == 2) ? h1 : cur1;
    assign rom_result2 = h2;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic verdict_t expect_v(input int mode, input int lm,
                                          input int ld, input int n0);
        verdict_t v;
        int seen;
        int p;
        v.err = 0;
        v.fev = 0;
        v.fea = 0;
        for (int k = 0; k < 64; k++) begin
            if (lm > ld) seen = int'(tt(mode, (k > 0) ? k - 1 : 0));
            else seen = int'(tt(mode, k));
            p = (k / 8) * (k % 8);
            if (seen != p) begin
                v.err++;
                if (v.fev == 0) begin
                    v.fev = 1;
                    v.fea = k;
                end
            end
        end
        v.pass = (v.err == 0) ? 1 : 0;
        v.cyc  = n0 + 64 + ld;
        v.busy = 64 + ld;
        return v;
    endfunction

    task automatic push_addrs();
        for (int k = 0; k < 64; k++) aq1.push_back(k);
    endtask

    always @(negedge clk) begin
        verdict_t v;
        if (rst) begin
            bc1 = 0;
            ec1 = 0;
            bc2 = 0;
        end else begin
            if (busy1) bc1++;
            if (busy2) bc2++;
            if (rom_en1) begin
                ec1++;
                if (aq1.size() == 0) chk("en_extra", 1, 0);
                else chk("addr", int'({rom_a1, rom_b1}), aq1.pop_front());
            end
            if (done1) begin
                if (vq1.size() == 0) begin
                    chk("done_extra", 1, 0);
                end else begin
                    v = vq1.pop_front();
                    chk("done_cyc", cyc, v.cyc);
                    chk("pass", int'(pass1), v.pass);
                    chk("err_count", int'(err1), v.err);
                    chk("first_valid", int'(fev1), v.fev);
                    chk("first_addr", int'(fea1), v.fea);
                    chk("busy_cycles", bc1, v.busy);
                    chk("en_cycles", ec1, 64);
                end
                bc1 = 0;
                ec1 = 0;
            end
            if (done2) begin
                if (vq2.size() == 0) begin
                    chk("done2_extra", 1, 0);
                end else begin
                    v = vq2.pop_front();
                    chk("done2_cyc", cyc, v.cyc);
                    chk("pass2", int'(pass2), v.pass);
                    chk("err2", int'(err2), v.err);
                    chk("busy2_cycles", bc2, v.busy);
                end
                bc2 = 0;
            end
        end
    end

    task automatic kick1(input int mode, input int lm, input bit hold,
                         output int n0);
        @(negedge clk);
        mode1  = mode;
        mlat1  = lm;
        start1 = 1'b1;
        @(posedge clk);
        #1;
        n0 = cyc;
        vq1.push_back(expect_v(mode, lm, 1, n0));
        push_addrs();
        @(negedge clk);
        if (!hold) start1 = 1'b0;
    endtask

    task automatic wait_done1(input int budget);
        for (int i = 0; i < budget && vq1.size() != 0; i++) @(negedge clk);
        chk("done1_timeout", vq1.size(), 0);
    endtask

    task automatic wait_done2(input int budget);
        for (int i = 0; i < budget && vq2.size() != 0; i++) @(negedge clk);
        chk("done2_timeout", vq2.size(), 0);
    endtask

    initial begin
        int n0;
        int got;
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        start1   = 1'b0;
        start2   = 1'b0;
        mode1    = 0;
        mlat1    = 1;
        mode2    = 0;
        bc1      = 0;
        ec1      = 0;
        bc2      = 0;
        repeat (2) @(negedge clk);
        got = int'({rom_en1, busy1, done1, pass1, err1, fev1, fea1});
        chk("reset_outs", got, 0);
        chk("reset_addr", int'({rom_a1, rom_b1}), 0);
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);

        // clean sweep, then verdict held in IDLE
        kick1(0, 1, 1'b0, n0);
        wait_done1(200);
        repeat (10) @(negedge clk);
        chk("pass_hold", int'(pass1), 1);
        chk("busy_idle", int'(busy1), 0);

        // single corrupt entry a=5,b=7
        kick1(1, 1, 1'b0, n0);
        wait_done1(200);
        repeat (5) @(negedge clk);
        chk("err_hold", int'(err1), 1);
        chk("fea_hold", int'(fea1), 47);

        // memory returns zero everywhere
        kick1(2, 1, 1'b0, n0);
        wait_done1(200);

        // start re-pulsed in SWEEP, DRAIN and DONE
        kick1(0, 1, 1'b0, n0);
        while (cyc < n0 + 100) begin
            start1 = (cyc == n0 + 10 || cyc == n0 + 64 || cyc == n0 + 65);
            @(negedge clk);
        end
        start1 = 1'b0;
        chk("repulse_q", vq1.size(), 0);
        chk("repulse_busy", int'(busy1), 0);

        // start held high: second sweep begins on first IDLE cycle after DONE
        kick1(0, 1, 1'b1, n0);
        vq1.push_back(expect_v(0, 1, 1, n0 + 67));
        push_addrs();
        while (cyc < n0 + 70) @(negedge clk);
        start1 = 1'b0;
        wait_done1(250);

        // asynchronous reset while address 20 is presented
        kick1(0, 1, 1'b0, n0);
        for (int i = 0; i < 100; i++) begin
            if (rom_en1 && {rom_a1, rom_b1} == 6'd20) break;
            @(negedge clk);
        end
        chk("addr20_seen", int'({rom_a1, rom_b1}), 20);
        #2 rst = 1'b1;
        #1;
        got = int'({rom_en1, busy1, done1, pass1, err1, fev1, fea1});
        chk("abort_outs", got, 0);
        chk("abort_addr", int'({rom_a1, rom_b1}), 0);
        vq1.delete();
        aq1.delete();
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (80) @(negedge clk);
        chk("abort_idle", int'({busy1, done1, pass1}), 0);
        kick1(0, 1, 1'b0, n0);
        wait_done1(200);

        // 2-cycle memory on a latency-1 checker must fail
        kick1(0, 2, 1'b0, n0);
        wait_done1(200);
        chk("lat_mismatch_err", int'(err1 > 0), 1);
        mlat1 = 1;

        // latency-2 checker with matching memory
        @(negedge clk);
        start2 = 1'b1;
        @(posedge clk);
        #1;
        n0 = cyc;
        vq2.push_back(expect_v(0, 2, 2, n0));
        @(negedge clk);
        start2 = 1'b0;
        wait_done2(200);

        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
